// File: rtl/mem_xfer_pkg.sv
// Shared sizing constants and FSM state type for the memory transfer engine.
package mem_xfer_pkg;

    localparam int DW    = 8;   // data width
    localparam int AW    = 3;   // address width
    localparam int DEPTH = 8;   // words moved per start, equal to 2**AW

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } state_e;

endpackage

// File: rtl/mem_xfer_if.sv
// Bundle of start/status, host load port, source memory port and destination
// memory port. master = transfer controller view, slave = memories/host view.
// Optional macro XFER_CHECKSUM_EN adds the checksum signal.
interface mem_xfer_if #(
    parameter int DW = mem_xfer_pkg::DW,
    parameter int AW = mem_xfer_pkg::AW
);

    logic          start;
    logic          busy;
    logic          done;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_data;
    logic          host_err;
    logic [AW-1:0] AddrA;
    logic          WEA;
    logic [DW-1:0] DataInA;
    logic [DW-1:0] DOut1;
    logic [AW-1:0] AddrB;
    logic          WEB;
    logic [DW-1:0] DataInB;
`ifdef XFER_CHECKSUM_EN
    logic [DW-1:0] checksum;

    modport master (
        input  start, host_we, host_addr, host_data, DOut1,
        output busy, done, host_err, AddrA, WEA, DataInA, AddrB, WEB, DataInB,
        output checksum
    );

    modport slave (
        output start, host_we, host_addr, host_data, DOut1,
        input  busy, done, host_err, AddrA, WEA, DataInA, AddrB, WEB, DataInB,
        input  checksum
    );
`else
    modport master (
        input  start, host_we, host_addr, host_data, DOut1,
        output busy, done, host_err, AddrA, WEA, DataInA, AddrB, WEB, DataInB
    );

    modport slave (
        output start, host_we, host_addr, host_data, DOut1,
        input  busy, done, host_err, AddrA, WEA, DataInA, AddrB, WEB, DataInB
    );
`endif

endinterface

// File: rtl/mem_xfer_cksum.sv
// Running mod-2**DW sum of the words written to the destination memory.
// Cleared when a transfer is accepted, held between transfers.
module mem_xfer_cksum
    import mem_xfer_pkg::*;
#(
    parameter int DW = mem_xfer_pkg::DW
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear_i,
    input  logic          acc_i,
    input  logic [DW-1:0] data_i,
    output logic [DW-1:0] sum_o
);

    logic [DW-1:0] sum_q;
    logic [DW-1:0] sum_d;

    // Next sum: clear on accept, otherwise add the word being written.
    always_comb begin
        sum_d = sum_q;
        if (clear_i) begin
            sum_d = '0;
        end else if (acc_i) begin
            sum_d = sum_q + data_i;
        end
    end

    // Sum register.
    always_ff @(posedge clock) begin
        if (reset) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/mem_xfer_ctrl.sv
// Source-memory initiator and copy engine: passes host writes through to the
// source memory while idle, and on start streams all DEPTH source words into
// the destination memory at one word per clock.
// Optional macro XFER_CHECKSUM_EN adds a destination-write checksum.
module mem_xfer_ctrl
    import mem_xfer_pkg::*;
#(
    parameter int DW    = mem_xfer_pkg::DW,
    parameter int AW    = mem_xfer_pkg::AW,
    parameter int DEPTH = mem_xfer_pkg::DEPTH
) (
    input  logic       clock,
    input  logic       reset,
    mem_xfer_if.master bus
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] count_q, count_d;
    logic          web_q, web_d;
    logic [AW-1:0] addrb_q, addrb_d;
    logic          done_q, done_d;
    logic          herr_q, herr_d;

    logic [AW-1:0] addra;
    logic          wea;
    logic          rd_valid;
    logic [DW-1:0] rd_data;

    // Next state, read-issue address and host pass-through.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        addra    = bus.host_addr;
        wea      = bus.host_we;
        rd_valid = 1'b0;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = READ;
                    count_d = '0;
                end
            end
            READ: begin
                wea      = 1'b0;
                addra    = count_q;
                rd_valid = 1'b1;
                count_d  = count_q + 1'b1;
                if (count_q == LAST) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                wea     = 1'b0;
                addra   = count_q;
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        herr_d = bus.host_we && (state_q != IDLE);
    end

    // The destination write trails the read issue by one cycle, matching the
    // source memory's registered read, so DOut1 can feed DataInB directly.
    always_comb begin
        web_d   = rd_valid;
        addrb_d = addra;
    end

    // Control and write-pipeline registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            web_q   <= 1'b0;
            addrb_q <= '0;
            done_q  <= 1'b0;
            herr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            web_q   <= web_d;
            addrb_q <= addrb_d;
            done_q  <= done_d;
            herr_q  <= herr_d;
        end
    end

    assign rd_data      = bus.DOut1;
    assign bus.AddrA    = addra;
    assign bus.WEA      = wea;
    assign bus.DataInA  = bus.host_data;
    assign bus.AddrB    = addrb_q;
    assign bus.WEB      = web_q;
    assign bus.DataInB  = rd_data;
    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_q;
    assign bus.host_err = herr_q;

`ifdef XFER_CHECKSUM_EN
    logic accept;
    assign accept = (state_q == IDLE) && bus.start;

    mem_xfer_cksum #(
        .DW(DW)
    ) u_cksum (
        .clock   (clock),
        .reset   (reset),
        .clear_i (accept),
        .acc_i   (web_q),
        .data_i  (rd_data),
        .sum_o   (bus.checksum)
    );
`endif

endmodule

// File: tb/tb_mem_xfer_ctrl.sv
// Self-checking bench for mem_xfer_ctrl with source and destination memory
// models. Optional macro XFER_CHECKSUM_EN enables the checksum scenario.
module tb_mem_xfer_ctrl;
    import mem_xfer_pkg::*;

    logic clock = 1'b0;
    logic reset;

    mem_xfer_if bus ();

    mem_xfer_ctrl #(
        .DW    (DW),
        .AW    (AW),
        .DEPTH (DEPTH)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clock = ~clock;

    logic [DW-1:0] src_mem [DEPTH];
    logic [DW-1:0] dst_mem [DEPTH];
    logic [DW-1:0] exp_src [DEPTH];
    logic [DW-1:0] exp_dst [DEPTH];
    logic [DW-1:0] img     [DEPTH];
    logic [AW-1:0] prev_addra = '0;
    int errors = 0;
    int checks = 0;

    // Source memory: registered write and registered read.
    always @(posedge clock) begin
        if (bus.WEA) src_mem[bus.AddrA] <= bus.DataInA;
        bus.DOut1 <= src_mem[bus.AddrA];
    end

    // Destination memory: registered write.
    always @(posedge clock) begin
        if (bus.WEB) dst_mem[bus.AddrB] <= bus.DataInB;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "watchdog");
    end

    // Advance one clock; protocol rules are checked at the falling edge.
    task automatic cycle();
        @(negedge clock);
        if (!reset) begin
            checks++;
            if (bus.busy && bus.WEA) begin
                errors++;
                $display("FAIL proto_wea: WEA=%0b busy=%0b, required WEA=0 while busy", bus.WEA, bus.busy);
            end
            checks++;
            if (bus.WEB && (!bus.busy || bus.AddrB !== prev_addra)) begin
                errors++;
                $display("FAIL proto_web: WEB=1 busy=%0b AddrB=%0d, required busy=1 and AddrB=%0d", bus.busy, bus.AddrB, prev_addra);
            end
        end
        prev_addra = bus.AddrA;
        @(posedge clock);
        #1;
    endtask

    task automatic host_write(input int a, input logic [DW-1:0] d);
        bus.host_we   = 1'b1;
        bus.host_addr = AW'(a);
        bus.host_data = d;
        cycle();
        bus.host_we   = 1'b0;
        exp_src[a]    = d;
    endtask

    task automatic load_random();
        for (int k = 0; k < DEPTH; k++) host_write(k, DW'($urandom));
        for (int n = 0; n < int'($urandom_range(0, 4)); n++)
            host_write(int'($urandom_range(0, DEPTH - 1)), DW'($urandom));
    endtask

    task automatic wait_done(input int lat_in, output int lat);
        lat = lat_in;
        while (!bus.done && lat < 40) begin
            cycle();
            lat++;
        end
    endtask

    task automatic check_dst(input string tag);
        for (int k = 0; k < DEPTH; k++) begin
            checks++;
            if (dst_mem[k] !== exp_dst[k]) begin
                errors++;
                $display("FAIL %s dst[%0d]: got %02h, required %02h", tag, k, dst_mem[k], exp_dst[k]);
            end
        end
    endtask

    task automatic check_lat(input string tag, input int lat);
        checks++;
        if (lat !== 9) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles, required 9", tag, lat);
        end
    endtask

    // Start a transfer of the current source image and wait for done.
    task automatic start_and_wait(output int lat, output int busy_n);
        for (int k = 0; k < DEPTH; k++) img[k] = exp_src[k];
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        lat = 0;
        busy_n = 0;
        while (!bus.done && lat < 40) begin
            if (bus.busy) busy_n++;
            cycle();
            lat++;
        end
        for (int k = 0; k < DEPTH; k++) exp_dst[k] = img[k];
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.host_we = 1'b0;
        bus.host_addr = '0;
        bus.host_data = '0;
        reset = 1'b1;
        cycle();
        cycle();
        checks++;
        if ({bus.busy, bus.done, bus.host_err, bus.WEB} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: busy,done,host_err,WEB=%04b, required 0000", {bus.busy, bus.done, bus.host_err, bus.WEB});
        end
        checks++;
        if (bus.AddrB !== '0) begin
            errors++;
            $display("FAIL reset_addrb: got %0d, required 0", bus.AddrB);
        end
`ifdef XFER_CHECKSUM_EN
        checks++;
        if (bus.checksum !== '0) begin
            errors++;
            $display("FAIL reset_checksum: got %02h, required 00", bus.checksum);
        end
`endif
        reset = 1'b0;
        cycle();
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_busy: got %0b, required 0", bus.busy);
        end
    endtask

    task automatic test_basic();
        int lat, bn;
        for (int k = 0; k < DEPTH; k++) host_write(k, DW'(17 * (k + 1)));
        start_and_wait(lat, bn);
        check_lat("basic", lat);
        checks++;
        if (bn !== 9) begin
            errors++;
            $display("FAIL basic busy_cycles: got %0d, required 9", bn);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL basic busy_at_done: got %0b, required 0", bus.busy);
        end
        check_dst("basic");
        cycle();
        checks++;
        if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL basic done_width: done still %0b one cycle later, required 0", bus.done);
        end
    endtask

    task automatic test_random();
        int lat, bn;
        for (int r = 0; r < 4; r++) begin
            load_random();
            start_and_wait(lat, bn);
            check_lat("random", lat);
            check_dst("random");
            for (int n = 0; n < int'($urandom_range(0, 3)); n++) cycle();
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [DW-1:0] v;
        load_random();
        for (int k = 0; k < DEPTH; k++) img[k] = exp_src[k];
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        lat = 0;
        while (!bus.done && lat < 40) begin
            bus.start = (lat >= 2 && lat < 5);
            cycle();
            lat++;
        end
        bus.start = 1'b0;
        check_lat("held_start", lat);
        for (int k = 0; k < DEPTH; k++) exp_dst[k] = img[k];
        check_dst("held_start");
        // New start plus a host write in the done cycle.
        v = DW'($urandom);
        bus.start = 1'b1;
        bus.host_we = 1'b1;
        bus.host_addr = AW'(5);
        bus.host_data = v;
        exp_src[5] = v;
        for (int k = 0; k < DEPTH; k++) img[k] = exp_src[k];
        cycle();
        bus.start = 1'b0;
        bus.host_we = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b busy: got %0b, required 1 right after start in done cycle", bus.busy);
        end
        checks++;
        if (bus.host_err !== 1'b0) begin
            errors++;
            $display("FAIL b2b host_err: got %0b, required 0", bus.host_err);
        end
        wait_done(0, lat);
        check_lat("b2b", lat);
        for (int k = 0; k < DEPTH; k++) exp_dst[k] = img[k];
        check_dst("b2b");
    endtask

    task automatic test_host_err();
        int lat;
        load_random();
        host_write(3, DW'($urandom) & 8'h7F);
        for (int k = 0; k < DEPTH; k++) img[k] = exp_src[k];
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        cycle();
        cycle();
        bus.host_we = 1'b1;
        bus.host_addr = AW'(3);
        bus.host_data = 8'hFF;
        cycle();
        bus.host_we = 1'b0;
        checks++;
        if (bus.host_err !== 1'b1) begin
            errors++;
            $display("FAIL host_err pulse: got %0b, required 1", bus.host_err);
        end
        cycle();
        checks++;
        if (bus.host_err !== 1'b0) begin
            errors++;
            $display("FAIL host_err width: got %0b, required 0", bus.host_err);
        end
        wait_done(4, lat);
        check_lat("host_err", lat);
        for (int k = 0; k < DEPTH; k++) exp_dst[k] = img[k];
        check_dst("host_err");
        checks++;
        if (src_mem[3] !== exp_src[3]) begin
            errors++;
            $display("FAIL host_err src3: got %02h, required %02h", src_mem[3], exp_src[3]);
        end
    endtask

    task automatic test_reset_mid();
        int dones;
        for (int k = 0; k < DEPTH; k++) host_write(k, exp_dst[k] ^ (DW'($urandom) | 8'h01));
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        cycle();
        cycle();
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        checks++;
        if (bus.WEB !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid state: WEB=%0b busy=%0b, required 0 0", bus.WEB, bus.busy);
        end
        dones = 0;
        for (int n = 0; n < 12; n++) begin
            cycle();
            if (bus.done) dones++;
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL reset_mid done: saw %0d done pulses, required 0", dones);
        end
        for (int k = 0; k < 3; k++) exp_dst[k] = exp_src[k];
        check_dst("reset_mid");
    endtask

`ifdef XFER_CHECKSUM_EN
    task automatic test_checksum();
        int lat, bn;
        logic [DW-1:0] sum;
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (p == 0)      host_write(k, 8'h80);
                else if (p == 1) host_write(k, DW'(k + 1));
                else             host_write(k, DW'($urandom));
            end
            sum = '0;
            for (int k = 0; k < DEPTH; k++) sum = sum + exp_src[k];
            start_and_wait(lat, bn);
            check_lat("checksum", lat);
            checks++;
            if (bus.checksum !== sum) begin
                errors++;
                $display("FAIL checksum at_done: got %02h, required %02h", bus.checksum, sum);
            end
            cycle();
            cycle();
            cycle();
            checks++;
            if (bus.checksum !== sum) begin
                errors++;
                $display("FAIL checksum held: got %02h, required %02h", bus.checksum, sum);
            end
        end
    endtask
`endif

    initial begin
        reset = 1'b1;
        bus.start = 1'b0;
        bus.host_we = 1'b0;
        bus.host_addr = '0;
        bus.host_data = '0;
        test_reset();
        test_basic();
        test_random();
        test_back_to_back();
        test_host_err();
        test_reset_mid();
`ifdef XFER_CHECKSUM_EN
        test_checksum();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
